// File: rtl/angle_quadrant_reducer.sv
// Reduces an unsigned angle in degrees modulo 360 by restoring shift-subtract,
// then folds the remainder into a quadrant and a 0..90 reference angle for the trig LUTs.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// state    | meaning
// IDLE     | in_ready high, waiting for an angle
// REDUCE   | one conditional subtract of 360<<k per cycle, k counts down to 0
// CLASSIFY | rem in 0..359, map to quadrant / reference angle
// DONE     | result held until downstream takes it
module angle_quadrant_reducer #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] angle_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            quadrant,
  output logic [DATA_WIDTH-1:0] ref_angle
);

  localparam int N_ITER = DATA_WIDTH - 8;
  localparam int KW     = $clog2(N_ITER);
  localparam int CW     = DATA_WIDTH + 9;
  localparam logic [KW-1:0] K_LAST = KW'(N_ITER - 1);
  localparam logic [CW-1:0] DEG360 = CW'(360);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDUCE   = 2'd1,
    CLASSIFY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] rem;
  logic [KW-1:0]         k;

  logic [CW-1:0]         rem_ext;
  logic [CW-1:0]         sub_val;
  logic                  sub_ok;
  logic [DATA_WIDTH-1:0] rem_diff;
  logic [8:0]            rem9;
  logic [1:0]            q_next;
  logic [8:0]            ref_next;

  // Wide compare: 360<<k can exceed DATA_WIDTH only in the caller's imagination,
  // but the extra bits keep the compare honest for any legal width.
  assign rem_ext  = {9'b0, rem};
  assign sub_val  = DEG360 << k;
  assign sub_ok   = (rem_ext >= sub_val);
  assign rem_diff = rem - sub_val[DATA_WIDTH-1:0];
  assign rem9     = rem[8:0];

  always_comb begin
    q_next   = 2'd0;
    ref_next = rem9;
    if (rem9 <= 9'd90) begin
      q_next   = 2'd0;
      ref_next = rem9;
    end else if (rem9 <= 9'd180) begin
      q_next   = 2'd1;
      ref_next = 9'd180 - rem9;
    end else if (rem9 <= 9'd270) begin
      q_next   = 2'd2;
      ref_next = rem9 - 9'd180;
    end else begin
      q_next   = 2'd3;
      ref_next = 9'd360 - rem9;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rem       <= '0;
      k         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      quadrant  <= 2'd0;
      ref_angle <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            rem      <= angle_in;
            k        <= K_LAST;
            in_ready <= 1'b0;
            state    <= REDUCE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        REDUCE: begin
          if (sub_ok) rem <= rem_diff;
          k <= k - KW'(1);
          if (k == '0) state <= CLASSIFY;
        end
        CLASSIFY: begin
          quadrant  <= q_next;
          ref_angle <= {{(DATA_WIDTH-9){1'b0}}, ref_next};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_quadrant_reducer.sv
// Directed bench for angle_quadrant_reducer: hand-computed quadrant / reference angles,
// latency, backpressure and mid-reduction reset.
module tb_angle_quadrant_reducer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  quadrant;
  logic [31:0] ref_angle;

  int checks;
  int failures;

  angle_quadrant_reducer #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quadrant  (quadrant),
    .ref_angle (ref_angle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one angle, waits for the result, returns it and the accept-to-valid edge count,
  // then completes the output handshake. lat >= 200 means a timeout.
  task automatic do_transfer(input logic [31:0] a, output logic [1:0] q,
                             output logic [31:0] r, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    angle_in = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    angle_in = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quadrant;
    r = ref_angle;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    angle_in  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || quadrant !== 2'd0 || ref_angle !== 32'd0) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b q=%0d ref=%0d, required 0 0 0 0",
               in_ready, out_valid, quadrant, ref_angle);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL in_ready_before_edge: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_after_release: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [1:0]  q;
    logic [31:0] r;
    int          lat;
    do_transfer(32'd45, q, r, lat);
    checks++;
    if (lat !== 25) begin
      failures++;
      $display("FAIL latency_45: got %0d edges, required 25", lat);
    end
    checks++;
    if (q !== 2'd0 || r !== 32'd45) begin
      failures++;
      $display("FAIL basic_45: got q=%0d ref=%0d, required q=0 ref=45", q, r);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_return: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_quadrant_sweep();
    logic [31:0] a  [6] = '{32'd120, 32'd200, 32'd300, 32'd91, 32'd181, 32'd765};
    logic [1:0]  eq [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] er [6] = '{32'd60, 32'd20, 32'd60, 32'd89, 32'd1, 32'd45};
    logic [1:0]  q;
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      do_transfer(a[i], q, r, lat);
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        failures++;
        $display("FAIL sweep_%0d: got q=%0d ref=%0d, required q=%0d ref=%0d",
                 a[i], q, r, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] a  [7] = '{32'd0, 32'd90, 32'd180, 32'd270, 32'd360, 32'd359, 32'd271};
    logic [1:0]  eq [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3};
    logic [31:0] er [7] = '{32'd0, 32'd90, 32'd0, 32'd90, 32'd0, 32'd1, 32'd89};
    logic [1:0]  q;
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      do_transfer(a[i], q, r, lat);
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        failures++;
        $display("FAIL boundary_%0d: got q=%0d ref=%0d, required q=%0d ref=%0d",
                 a[i], q, r, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_large();
    logic [1:0]  q;
    logic [31:0] r;
    int          lat;
    // 2^32-1 mod 360 = 255
    do_transfer(32'hFFFF_FFFF, q, r, lat);
    checks++;
    if (q !== 2'd2 || r !== 32'd75) begin
      failures++;
      $display("FAIL large_ffffffff: got q=%0d ref=%0d, required q=2 ref=75", q, r);
    end
    // 2^31 mod 360 = 128
    do_transfer(32'h8000_0000, q, r, lat);
    checks++;
    if (q !== 2'd1 || r !== 32'd52) begin
      failures++;
      $display("FAIL large_80000000: got q=%0d ref=%0d, required q=1 ref=52", q, r);
    end
    // 360<<23 exactly, exercises the top subtract step
    do_transfer(32'd3019898880, q, r, lat);
    checks++;
    if (q !== 2'd0 || r !== 32'd0) begin
      failures++;
      $display("FAIL large_360x2p23: got q=%0d ref=%0d, required q=0 ref=0", q, r);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    angle_in = 32'd200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || quadrant !== 2'd2 || ref_angle !== 32'd20) begin
      failures++;
      $display("FAIL bp_result: out_valid=%b q=%0d ref=%0d, required 1 2 20",
               out_valid, quadrant, ref_angle);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      angle_in = 32'd100 + 32'(c);
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quadrant !== 2'd2 || ref_angle !== 32'd20)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d cycles disturbed, required 0", bad);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quadrant !== 2'd2 || ref_angle !== 32'd20) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b q=%0d ref=%0d, required 0 1 2 20",
               out_valid, in_ready, quadrant, ref_angle);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0]  q;
    logic [31:0] r;
    int          lat;
    int          n;
    int          seen;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    angle_in = 32'd300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || quadrant !== 2'd0 || ref_angle !== 32'd0) begin
      failures++;
      $display("FAIL abort_reset_values: in_ready=%b out_valid=%b q=%0d ref=%0d, required 0 0 0 0",
               in_ready, out_valid, quadrant, ref_angle);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_out_valid: out_valid high %0d cycles, required 0", seen);
    end
    do_transfer(32'd45, q, r, lat);
    checks++;
    if (q !== 2'd0 || r !== 32'd45 || lat !== 25) begin
      failures++;
      $display("FAIL abort_recover_45: got q=%0d ref=%0d lat=%0d, required q=0 ref=45 lat=25",
               q, r, lat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_quadrant_sweep();
    test_boundaries();
    test_large();
    test_backpressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
